// File: rtl/hfifo_drain.sv
// Read-side consumer for hfifo: pops a word whenever data is available, holds it on the
// display/LED outputs for HOLD_CYCLES, and flags any break in the incrementing word stream.
module hfifo_drain #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 100000000,
  parameter int HOLD_W      = 28,
  parameter int COUNT_W     = 16
) (
  input  logic               SYSTEM_CLOCK,
  input  logic               reset,
  input  logic               enable,
  input  logic               fifo_rdy,
  input  logic [WIDTH-1:0]   fifo_dout,
  output logic               fifo_pop,
  output logic [WIDTH-1:0]   disp_data,
  output logic [COUNT_W-1:0] word_count,
  output logic               seq_error,
  output logic               busy,
  output logic               LED_0,
  output logic               LED_1,
  output logic               LED_2,
  output logic               LED_3
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0]  HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  // Next value of the expected stream word; wraps naturally at 2^WIDTH.
  function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] w);
    return w + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Saturating increment so the word counter never wraps back to zero.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    logic [COUNT_W-1:0] r;
    if (c == COUNT_MAX) begin
      r = c;
    end else begin
      r = c + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  state_t             state_r,    state_s;
  logic [HOLD_W-1:0]  hold_cnt_r, hold_cnt_s;
  logic [WIDTH-1:0]   expected_r, expected_s;
  logic [WIDTH-1:0]   disp_r,     disp_s;
  logic [COUNT_W-1:0] count_r,    count_s;
  logic               seq_err_r,  seq_err_s;
  logic               pop_r,      pop_s;
  logic               busy_r,     busy_s;

  // Next-state and next-output logic for the IDLE/HOLD sequencer.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    expected_s = expected_r;
    disp_s     = disp_r;
    count_s    = count_r;
    seq_err_s  = seq_err_r;
    pop_s      = 1'b0;

    case (state_r)
      IDLE: begin
        if (enable && fifo_rdy) begin
          pop_s      = 1'b1;
          disp_s     = fifo_dout;
          hold_cnt_s = HOLD_LOAD;
          state_s    = HOLD;
          count_s    = sat_inc(count_r);
          // Resync to the captured word so one glitch reports once, not forever.
          expected_s = next_word(fifo_dout);
          if (fifo_dout != expected_r) begin
            seq_err_s = 1'b1;
          end else begin
            seq_err_s = seq_err_r;
          end
        end else begin
          state_s = IDLE;
        end
      end
      HOLD: begin
        if (hold_cnt_r != HOLD_ZERO) begin
          hold_cnt_s = hold_cnt_r - HOLD_ONE;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s    = IDLE;
        hold_cnt_s = HOLD_ZERO;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State and output registers; reset aborts any hold immediately.
  always_ff @(posedge SYSTEM_CLOCK or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      hold_cnt_r <= HOLD_ZERO;
      expected_r <= {WIDTH{1'b0}};
      disp_r     <= {WIDTH{1'b0}};
      count_r    <= {COUNT_W{1'b0}};
      seq_err_r  <= 1'b0;
      pop_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      expected_r <= expected_s;
      disp_r     <= disp_s;
      count_r    <= count_s;
      seq_err_r  <= seq_err_s;
      pop_r      <= pop_s;
      busy_r     <= busy_s;
    end
  end

  assign fifo_pop   = pop_r;
  assign disp_data  = disp_r;
  assign word_count = count_r;
  assign seq_error  = seq_err_r;
  assign busy       = busy_r;
  assign LED_0      = disp_r[0];
  assign LED_1      = disp_r[1];
  assign LED_2      = disp_r[2];
  assign LED_3      = disp_r[3];

endmodule

// File: tb/tb_hfifo_drain.sv
// Self-checking bench for hfifo_drain: a model FIFO feeds words, a scoreboard queue holds the
// words expected on disp_data at each pop, and per-scenario tasks check timing and status.
module tb_hfifo_drain;
  localparam int WIDTH       = 4;
  localparam int HOLD_CYCLES = 4;
  localparam int HOLD_W      = 3;
  localparam int COUNT_W     = 4;

  logic               SYSTEM_CLOCK = 1'b0;
  logic               reset;
  logic               enable;
  logic               fifo_rdy;
  logic [WIDTH-1:0]   fifo_dout;
  logic               fifo_pop;
  logic [WIDTH-1:0]   disp_data;
  logic [COUNT_W-1:0] word_count;
  logic               seq_error;
  logic               busy;
  logic               LED_0, LED_1, LED_2, LED_3;

  logic [WIDTH-1:0] mem [0:255];
  logic [7:0]       rd_ptr;
  logic [7:0]       wr_ptr;
  logic             rdy_en;
  logic [WIDTH-1:0] exp_q [$];

  int   n_checks;
  int   n_fail;
  int   pops;
  int   cyc;
  int   last_pop_cyc;
  int   last_gap;
  logic pop_prev;

  assign fifo_rdy  = rdy_en && (rd_ptr != wr_ptr);
  assign fifo_dout = mem[rd_ptr];

  hfifo_drain #(
    .WIDTH(WIDTH), .HOLD_CYCLES(HOLD_CYCLES), .HOLD_W(HOLD_W), .COUNT_W(COUNT_W)
  ) dut (
    .SYSTEM_CLOCK(SYSTEM_CLOCK), .reset(reset), .enable(enable),
    .fifo_rdy(fifo_rdy), .fifo_dout(fifo_dout), .fifo_pop(fifo_pop),
    .disp_data(disp_data), .word_count(word_count), .seq_error(seq_error), .busy(busy),
    .LED_0(LED_0), .LED_1(LED_1), .LED_2(LED_2), .LED_3(LED_3)
  );

  always #5 SYSTEM_CLOCK = ~SYSTEM_CLOCK;

  task automatic push_word(input logic [WIDTH-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
    exp_q.push_back(w);
  endtask

  // One clock; on a pop, score disp_data against the queue and advance the model FIFO.
  task automatic step();
    logic [WIDTH-1:0] e;
    @(posedge SYSTEM_CLOCK);
    cyc++;
    @(negedge SYSTEM_CLOCK);
    if (fifo_pop === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: pop seen, disp_data=%0h, no word expected", disp_data);
      end else begin
        e = exp_q.pop_front();
        if (disp_data !== e) begin
          n_fail++;
          $display("FAIL pop_data: disp_data=%0h expected %0h", disp_data, e);
        end
      end
      n_checks++;
      if (pop_prev === 1'b1) begin
        n_fail++;
        $display("FAIL pop_width: fifo_pop high %0d consecutive cycles, expected 1", 2);
      end
      last_gap     = cyc - last_pop_cyc;
      last_pop_cyc = cyc;
      pops++;
      rd_ptr = rd_ptr + 8'd1;
    end
    pop_prev = fifo_pop;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    rdy_en = 1'b0;
    step();
    step();
    rd_ptr = wr_ptr;
    exp_q.delete();
    pop_prev = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    int p;
    step();
    step();
    n_checks++;
    if ({fifo_pop, busy, seq_error, disp_data, word_count, LED_3, LED_2, LED_1, LED_0} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_state: pop=%b busy=%b err=%b disp=%0h cnt=%0d, expected all 0",
               fifo_pop, busy, seq_error, disp_data, word_count);
    end
    reset = 1'b0;
    push_word(4'h5);
    rdy_en = 1'b1;
    enable = 1'b1;
    p = pops;
    for (int i = 0; i < 10 && pops == p; i++) step();
    n_checks++;
    if (pops == p) begin
      n_fail++;
      $display("FAIL reset_first_pop: pops=%0d expected %0d", pops, p + 1);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (fifo_pop !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort_ctl: pop=%b busy=%b expected 0 0", fifo_pop, busy);
    end
    n_checks++;
    if (disp_data !== 4'h0 || word_count !== 4'd0 || seq_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort_data: disp=%0h cnt=%0d err=%b expected 0 0 0",
               disp_data, word_count, seq_error);
    end
    rdy_en = 1'b0;
    step();
    reset = 1'b0;
    p = pops;
    repeat (20) step();
    n_checks++;
    if (pops != p || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: pops=%0d busy=%b expected %0d 0", pops, busy, p);
    end
  endtask

  task automatic test_basic();
    int p0, prev;
    push_word(4'h0);
    push_word(4'h1);
    push_word(4'h2);
    rdy_en = 1'b1;
    enable = 1'b1;
    p0 = pops;
    step();
    n_checks++;
    if (pops != p0 + 1) begin
      n_fail++;
      $display("FAIL basic_latency: pops=%0d expected %0d one cycle after rdy", pops, p0 + 1);
    end
    for (int i = 0; i < 40 && pops < p0 + 3; i++) begin
      prev = pops;
      step();
      if (pops != prev) begin
        n_checks++;
        if (last_gap != HOLD_CYCLES + 1) begin
          n_fail++;
          $display("FAIL basic_spacing: pop gap=%0d expected %0d", last_gap, HOLD_CYCLES + 1);
        end
      end
    end
    n_checks++;
    if (pops != p0 + 3 || word_count !== 4'd3 || seq_error !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_count: pops=%0d cnt=%0d err=%b expected %0d 3 0",
               pops, word_count, seq_error, p0 + 3);
    end
    rdy_en = 1'b0;
    repeat (10) step();
    n_checks++;
    if (pops != p0 + 3 || disp_data !== 4'h2 || busy !== 1'b0 ||
        {LED_3, LED_2, LED_1, LED_0} !== 4'h2) begin
      n_fail++;
      $display("FAIL basic_empty_hold: pops=%0d disp=%0h busy=%b leds=%b expected %0d 2 0 0010",
               pops, disp_data, busy, {LED_3, LED_2, LED_1, LED_0}, p0 + 3);
    end
  endtask

  task automatic test_wrap();
    int p0, prev;
    do_reset();
    for (int w = 0; w < 16; w++) push_word(4'(w));
    push_word(4'h0);
    push_word(4'h1);
    rdy_en = 1'b1;
    enable = 1'b1;
    p0 = pops;
    for (int i = 0; i < 130 && pops < p0 + 18; i++) begin
      prev = pops;
      step();
      if (pops != prev && pops == p0 + 16) begin
        n_checks++;
        if (word_count !== 4'd15) begin
          n_fail++;
          $display("FAIL wrap_saturate: cnt=%0d expected 15 after 16 pops", word_count);
        end
      end
    end
    n_checks++;
    if (pops != p0 + 18 || seq_error !== 1'b0 || word_count !== 4'd15 || disp_data !== 4'h1) begin
      n_fail++;
      $display("FAIL wrap_end: pops=%0d err=%b cnt=%0d disp=%0h expected %0d 0 15 1",
               pops, seq_error, word_count, disp_data, p0 + 18);
    end
  endtask

  task automatic test_seq_error();
    int p0, prev;
    do_reset();
    push_word(4'h0);
    push_word(4'h1);
    push_word(4'h3);
    push_word(4'h4);
    push_word(4'h5);
    rdy_en = 1'b1;
    enable = 1'b1;
    p0 = pops;
    for (int i = 0; i < 40 && pops < p0 + 5; i++) begin
      prev = pops;
      step();
      if (pops != prev && pops == p0 + 2) begin
        n_checks++;
        if (seq_error !== 1'b0) begin
          n_fail++;
          $display("FAIL seq_err_early: err=%b expected 0 after words 0,1", seq_error);
        end
      end
      if (pops != prev && pops == p0 + 3) begin
        n_checks++;
        if (seq_error !== 1'b1) begin
          n_fail++;
          $display("FAIL seq_err_set: err=%b expected 1 at capture of 3", seq_error);
        end
      end
    end
    n_checks++;
    if (pops != p0 + 5 || seq_error !== 1'b1 || word_count !== 4'd5) begin
      n_fail++;
      $display("FAIL seq_err_sticky: pops=%0d err=%b cnt=%0d expected %0d 1 5",
               pops, seq_error, word_count, p0 + 5);
    end
  endtask

  task automatic test_enable_drop();
    int p;
    do_reset();
    for (int w = 0; w < 5; w++) push_word(4'(w));
    rdy_en = 1'b1;
    enable = 1'b1;
    p = pops;
    for (int i = 0; i < 10 && pops == p; i++) step();
    step();
    enable = 1'b0;
    step();
    step();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL en_drop_hold: busy=%b expected 1 while hold completes", busy);
    end
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL en_drop_idle: busy=%b expected 0 after hold", busy);
    end
    p = pops;
    repeat (15) step();
    n_checks++;
    if (pops != p) begin
      n_fail++;
      $display("FAIL en_drop_nopop: pops=%0d expected %0d with enable low", pops, p);
    end
    enable = 1'b1;
    step();
    n_checks++;
    if (pops != p + 1) begin
      n_fail++;
      $display("FAIL en_raise_pop: pops=%0d expected %0d one cycle after enable", pops, p + 1);
    end
  endtask

  task automatic test_rdy_glitch();
    int p0;
    do_reset();
    push_word(4'h0);
    push_word(4'h1);
    rdy_en = 1'b1;
    enable = 1'b1;
    p0 = pops;
    for (int i = 0; i < 10 && pops == p0; i++) step();
    rdy_en = 1'b0;
    step();
    step();
    rdy_en = 1'b1;
    step();
    rdy_en = 1'b0;
    repeat (10) step();
    n_checks++;
    if (pops != p0 + 1 || word_count !== 4'd1 || disp_data !== 4'h0) begin
      n_fail++;
      $display("FAIL rdy_glitch: pops=%0d cnt=%0d disp=%0h expected %0d 1 0",
               pops, word_count, disp_data, p0 + 1);
    end
    rdy_en = 1'b1;
    step();
    n_checks++;
    if (pops != p0 + 2 || word_count !== 4'd2) begin
      n_fail++;
      $display("FAIL rdy_resume: pops=%0d cnt=%0d expected %0d 2", pops, word_count, p0 + 2);
    end
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    rdy_en       = 1'b0;
    rd_ptr       = 8'd0;
    wr_ptr       = 8'd0;
    n_checks     = 0;
    n_fail       = 0;
    pops         = 0;
    cyc          = 0;
    last_pop_cyc = 0;
    last_gap     = 0;
    pop_prev     = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_seq_error();
    test_enable_drop();
    test_rdy_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
